// File: rtl/pulse_stretcher_if.sv
// Event/indicator bundle between a pulse source and pulse_stretcher.
// master drives events and the overflow clear; slave returns the stretched LED and queue status.
interface pulse_stretcher_if;
  logic       pulse_in;
  logic       clr_ovf;
  logic       led_n;
  logic       busy;
  logic [7:0] pending;
  logic       overflow;

  modport master (output pulse_in, clr_ovf, input led_n, busy, pending, overflow);
  modport slave  (input pulse_in, clr_ovf, output led_n, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle events into HOLD_CYCLES-long active-low LED pulses separated by GAP_CYCLES.
// Define PULSE_STRETCHER_QUEUE_EN to queue events that arrive while busy; otherwise they are dropped.
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pulse_stretcher_if.slave  ps
);

  localparam int unsigned PEND_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  // Reject configurations whose load values would not fit the counter.
  if (HOLD_CYCLES == 0 || GAP_CYCLES == 0 || MAX_PENDING == 0 || MAX_PENDING > 255 ||
      64'(HOLD_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
      64'(GAP_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_param
    $error("pulse_stretcher: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_Idle, S_Hold, S_Gap} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic              led_n_q, led_n_d;
  logic              busy_q, busy_d;

  logic cnt_done;
  logic accept;
  logic restart;
  logic ovf_event;

  assign cnt_done = (cnt_q == '0);
  assign accept   = ps.pulse_in && (state_q != S_Idle);

`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  // Gap ends straight into a new hold when anything is waiting, including a same-cycle event.
  assign restart = (state_q == S_Gap) && cnt_done && ((pending_q != '0) || ps.pulse_in);
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_Idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_Idle:  if (ps.pulse_in) state_d = S_Hold;
      S_Hold:  if (cnt_done) state_d = S_Gap;
      S_Gap:   if (cnt_done) state_d = restart ? S_Hold : S_Idle;
      default: state_d = S_Idle;
    endcase
  end

  always_comb begin
    led_n_d = (state_d != S_Hold);
    busy_d  = (state_d != S_Idle);
  end

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovf_event = 1'b0;

    // Counter reloads on every state change and otherwise counts down, parking at zero.
    if (state_d != state_q) begin
      case (state_d)
        S_Hold:  cnt_d = HOLD_LOAD;
        S_Gap:   cnt_d = GAP_LOAD;
        default: cnt_d = '0;
      endcase
    end else if (!cnt_done) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

`ifdef PULSE_STRETCHER_QUEUE_EN
    if (accept && !restart) begin
      if (pending_q == PEND_MAX) ovf_event = 1'b1;
      else                       pending_d = pending_q + PEND_W'(1);
    end else if (!accept && restart) begin
      pending_d = pending_q - PEND_W'(1);
    end
`else
    pending_d = '0;
    ovf_event = accept;
`endif

    ovf_d = (ovf_q && !ps.clr_ovf) || ovf_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      led_n_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      led_n_q   <= led_n_d;
      busy_q    <= busy_d;
    end
  end

  assign ps.led_n    = led_n_q;
  assign ps.busy     = busy_q;
  assign ps.pending  = pending_q;
  assign ps.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD=4, GAP=2, MAX_PENDING=3.
// Queue-mode expectations are selected by PULSE_STRETCHER_QUEUE_EN.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_stretcher_if ps_if ();

  pulse_stretcher #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .MAX_PENDING(3),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps (ps_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic       pulse;
    logic       clr;
    logic       exp_led_n;
    logic       exp_busy;
    logic [7:0] exp_pending;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rb, input logic p, input logic c, input logic l,
                     input logic b, input int pend, input logic o);
    vec_t v;
    v.rst_before  = rb;
    v.pulse       = p;
    v.clr         = c;
    v.exp_led_n   = l;
    v.exp_busy    = b;
    v.exp_pending = 8'(pend);
    v.exp_ovf     = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic b,
                           input logic [7:0] pend, input logic o);
    check({tag, " led_n"},    8'(ps_if.led_n),    8'(l));
    check({tag, " busy"},     8'(ps_if.busy),     8'(b));
    check({tag, " pending"},  ps_if.pending,      pend);
    check({tag, " overflow"}, 8'(ps_if.overflow), 8'(o));
  endtask

  // Asserts reset with pulse_in held high (must be ignored), returns at a negedge with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ps_if.pulse_in = 1'b1;
    ps_if.clr_ovf  = 1'b0;
    #1;
    check_all("reset async", 1'b1, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset held", 1'b1, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ps_if.pulse_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ps_if.pulse_in = 1'b0;
    ps_if.clr_ovf  = 1'b0;

    // Single pulse at cycle 0: low cycles 1-4, busy through cycle 6, idle at 7.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
`ifdef PULSE_STRETCHER_QUEUE_EN
    // Pulses at 0,2,3: lows 1-4, 7-10, 13-16.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 2, 0);
    add(0, 0, 0, 1, 1, 2, 0);
    add(0, 0, 0, 1, 1, 2, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    // Saturation at 3; overflow event wins over a same-cycle clear, then a clear alone.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 2, 0);
    add(0, 1, 0, 0, 1, 3, 0);
    add(0, 1, 1, 1, 1, 3, 1);
    add(0, 0, 1, 1, 1, 3, 0);
    add(0, 0, 0, 0, 1, 2, 0);
    // Pulse on the last gap cycle with nothing pending restarts directly.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
`else
    // Pulses while busy are dropped and flag overflow; the gap always exits to idle.
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      ps_if.pulse_in = vecs[i].pulse;
      ps_if.clr_ovf  = vecs[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].exp_led_n, vecs[i].exp_busy,
                vecs[i].exp_pending, vecs[i].exp_ovf);
      @(negedge clk);
    end
    ps_if.pulse_in = 1'b0;
    ps_if.clr_ovf  = 1'b0;

    // Reset mid-hold with events queued, then first event on the first edge after release.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ps_if.pulse_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
`ifdef PULSE_STRETCHER_QUEUE_EN
    check_all("mid-hold", 1'b0, 1'b1, 8'd2, 1'b0);
`else
    check_all("mid-hold", 1'b0, 1'b1, 8'd0, 1'b1);
`endif
    rst = 1'b1;
    #1;
    check_all("rst mid-hold", 1'b1, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst pulse ignored", 1'b1, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("first edge event", 1'b0, 1'b1, 8'd0, 1'b0);
    @(negedge clk);
    ps_if.pulse_in = 1'b0;
    @(posedge clk);
    #1;
    check_all("after first event", 1'b0, 1'b1, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, number of clk cycles led_n is held low per event (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 12500000, number of clk cycles led_n is held high between queued events (legal range 1..2^CNT_W-1).
REQ-003 The block SHALL have parameter MAX_PENDING, default 7, maximum queued events (legal range 1..255).
REQ-004 The block SHALL have parameter CNT_W, default 32, width of the internal hold/gap counter.
REQ-005 Port clk  input  1  the block's one clock; all state SHALL change on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port pulse_in  input  1  one-cycle active-high event, e.g. from a button shaper.
REQ-008 Port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 Port led_n  output  1  active-low stretched output, registered.
REQ-010 Port busy  output  1  high whenever state is not S_Idle.
REQ-011 Port pending  output  8  number of queued, not-yet-started events.
REQ-012 Port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 The FSM SHALL have states S_Idle, S_Hold, S_Gap.
REQ-014 In S_Idle with pulse_in=1 on a rising edge, the next state SHALL be S_Hold and led_n SHALL be 0 from the following cycle (latency 1 cycle).
REQ-015 S_Hold SHALL last exactly HOLD_CYCLES cycles with led_n=0, then go to S_Gap.
REQ-016 S_Gap SHALL last exactly GAP_CYCLES cycles with led_n=1; on its last cycle the next state SHALL be S_Hold if (pending>0 or pulse_in=1), else S_Idle.
REQ-017 pulse_in=1 in S_Hold or S_Gap SHALL increment pending, except as in REQ-018/019.
REQ-018 On a transition S_Gap->S_Hold, one event SHALL be consumed; a same-cycle pulse_in SHALL net pending unchanged (pending+1-1).
REQ-019 pulse_in=1 with pending=MAX_PENDING and no same-cycle consumption SHALL leave pending unchanged and set overflow=1.
REQ-020 overflow SHALL stay 1 until clr_ovf=1 on a rising edge or reset; if clr_ovf and a new overflow event coincide, overflow SHALL be 1.
REQ-021 The hold/gap counter SHALL reload on every state entry and never wrap; no arithmetic SHALL exceed CNT_W bits.
REQ-022 pulse_in in S_Idle SHALL never change pending.
REQ-023 busy SHALL be registered consistent with state (1 in S_Hold and S_Gap).

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state=S_Idle, led_n=1, busy=0, pending=0, overflow=0, counter=0.
REQ-025 Reset asserted mid-S_Hold SHALL release led_n to 1 at once and discard all queued events; pulse_in is ignored while rst=1.
REQ-026 First event accepted SHALL be a pulse_in sampled on the first rising edge with rst=0.

Configuration
REQ-027 Macro PULSE_STRETCHER_QUEUE_EN defined: queuing per REQ-017..020 SHALL be compiled in.
REQ-028 Macro PULSE_STRETCHER_QUEUE_EN undefined: pulse_in outside S_Idle SHALL be dropped and set overflow; pending SHALL read constant 0; S_Gap SHALL always exit to S_Idle.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3, queue enabled unless noted)
REQ-029 Single pulse at cycle 0 -> led_n=0 cycles 1-4, 1 from cycle 5; busy=1 cycles 1-6; Idle at cycle 7.
REQ-030 Pulses at cycles 0, 2, 3 -> pending=2 after cycle 3; led_n low cycles 1-4, 7-10, 13-16; pending back to 0 at cycle 13.
REQ-031 Pulse in Idle then 4 pulses during S_Hold -> pending saturates at 3, overflow=1; clr_ovf pulse -> overflow=0, pending still 3.
REQ-032 Pulse on last S_Gap cycle (cycle 6) with pending=0 -> S_Hold at cycle 7, pending stays 0.
REQ-033 rst asserted at cycle 2 of S_Hold with pending=2 -> led_n=1, pending=0, busy=0 before next edge.
REQ-034 Queue disabled: pulses at cycles 0 and 2 -> one 4-cycle low, overflow=1, pending=0.
